// File: rtl/spi_master_cmd.sv
// spi_master_cmd: mode-0 SPI master sending one 32-bit {cmd,data} frame per request and capturing 32 miso bits.
module spi_master_cmd #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] cmd,
    input  logic [15:0] data,
    output logic        busy,
    output logic        done,
    output logic [31:0] rx_data,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    input  logic        miso
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [31:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
    logic        sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
    logic        busy_q, busy_d, done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // One counter serves as setup/hold/gap timer and as the sclk half-period divider.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    tx_d    = {cmd, data};
                    mosi_d  = cmd[15];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // The setup interval doubles as the low half of bit 0.
                if (cnt_q == 16'(CS_SETUP - 1)) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[30:0], miso};
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == 16'(CLK_DIV - 1)) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_d = {rx_q[30:0], miso};
                    end else if (bit_q == 5'd31) begin
                        state_d = HOLD;
                    end else begin
                        bit_d  = bit_q + 5'd1;
                        tx_d   = {tx_q[30:0], 1'b0};
                        mosi_d = tx_q[30];
                    end
                end
            end
            HOLD: begin
                // Last bit's low half plus the chip-select hold time.
                if (cnt_q == 16'(CLK_DIV + CS_HOLD - 1)) begin
                    cnt_d     = '0;
                    cs_n_d    = 1'b1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_q;
                    done_d    = 1'b1;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (cnt_q == 16'(CS_IDLE - 1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
endmodule
